// File: rtl/uart_bus_slave.sv
// uart_bus_slave: register-mapped UART with a host bus slave port (ce/we/adr/dat) and tx/rx pins.
// Registers: 0 THR/RX data, 1 status, 2 control {ie_tx, ie_rx}, 3 bit divisor.
// Define UART_PARITY_EN to add an even-parity bit after D7 in both directions.
//
// state   | meaning
// --------+--------------------------------------------------
// S_IDLE  | line idle; TX waits for THR, RX waits for a falling edge
// S_START | start bit (RX: qualify at mid-bit, reject if high)
// S_DATA  | eight data bits, LSB first
// S_PAR   | even-parity bit (parity builds only)
// S_STOP  | stop bit; RX commits the byte or raises fe/ovr here
module uart_bus_slave #(
   parameter int DEFAULT_DIV = 15,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       arst_n,
   input  logic       ce,
   input  logic       we,
   input  logic [1:0] adr,
   inout  wire  [7:0] dat,
   input  logic       rx,
   output logic       tx,
   output logic       inter
);

`ifdef UART_PARITY_EN
   localparam logic PAR_EN = 1'b1;
`else
   localparam logic PAR_EN = 1'b0;
`endif

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_PAR   = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;

   logic [7:0] thr;
   logic       thr_full;
   logic [7:0] div;
   logic       ie_tx, ie_rx;
   logic [7:0] rx_data;
   logic       rx_full, pe, fe, ovr;

   logic [2:0] tx_st;
   logic [7:0] tx_cnt;
   logic [7:0] tx_sh;
   logic [2:0] tx_bit;
   logic       tx_par;

   logic [SYNC_STAGES-1:0] rx_sync;
   logic       rx_s, rx_prev;
   logic [2:0] rx_st;
   logic [7:0] rx_cnt;
   logic [7:0] rx_sh;
   logic [2:0] rx_bit;
   logic       rx_par;
   logic [7:0] rx_half;

   logic       rd, wr, pop, clr, tx_load, tx_idle;
   logic [7:0] rdata;

   assign rd      = ce & ~we;
   assign wr      = ce & we;
   assign pop     = rd && (adr == 2'd0);
   assign clr     = rd && (adr == 2'd1);
   assign tx_load = (tx_st == S_IDLE) && thr_full;
   assign tx_idle = (tx_st == S_IDLE) && !thr_full;
   assign rx_s    = rx_sync[SYNC_STAGES-1];
   // first RX sample lands mid start bit, counted from the synchronised falling edge
   assign rx_half = 8'(({1'b0, div} + 9'd1) >> 1) - 8'd1;

   // read-data mux; dat is driven only during a read access
   always_comb begin
      rdata = 8'h00;
      case (adr)
         2'd0:    rdata = rx_data;
         2'd1:    rdata = {2'b00, pe, fe, ovr, tx_idle, ~thr_full, rx_full};
         2'd2:    rdata = {6'b0, ie_tx, ie_rx};
         default: rdata = div;
      endcase
   end

   assign dat   = rd ? rdata : 8'bz;
   assign inter = (ie_rx & rx_full) | (ie_tx & ~thr_full);

   // host writes: THR (accepted when empty or on the load edge), control, divisor
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         thr      <= 8'h00;
         thr_full <= 1'b0;
         ie_tx    <= 1'b0;
         ie_rx    <= 1'b0;
         div      <= 8'(DEFAULT_DIV);
      end else begin
         if (tx_load)
            thr_full <= 1'b0;
         if (wr) begin
            case (adr)
               2'd0: if (!thr_full || tx_load) begin
                  thr      <= dat;
                  thr_full <= 1'b1;
               end
               2'd2: {ie_tx, ie_rx} <= dat[1:0];
               2'd3: div <= dat;
               default: ;
            endcase
         end
      end
   end

   // transmit FSM; tx is registered so it changes exactly on state edges
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         tx_st  <= S_IDLE;
         tx     <= 1'b1;
         tx_cnt <= 8'h00;
         tx_sh  <= 8'h00;
         tx_bit <= 3'd0;
         tx_par <= 1'b0;
      end else begin
         case (tx_st)
            S_IDLE: if (thr_full) begin
               tx_sh  <= thr;
               tx_par <= ^thr;
               tx     <= 1'b0;
               tx_cnt <= div;
               tx_st  <= S_START;
            end
            S_START: if (tx_cnt == 8'd0) begin
               tx     <= tx_sh[0];
               tx_cnt <= div;
               tx_bit <= 3'd0;
               tx_st  <= S_DATA;
            end else tx_cnt <= tx_cnt - 8'd1;
            S_DATA: if (tx_cnt == 8'd0) begin
               tx_cnt <= div;
               if (tx_bit == 3'd7) begin
                  tx    <= PAR_EN ? tx_par : 1'b1;
                  tx_st <= PAR_EN ? S_PAR : S_STOP;
               end else begin
                  tx     <= tx_sh[1];
                  tx_sh  <= tx_sh >> 1;
                  tx_bit <= tx_bit + 3'd1;
               end
            end else tx_cnt <= tx_cnt - 8'd1;
            S_PAR: if (tx_cnt == 8'd0) begin
               tx     <= 1'b1;
               tx_cnt <= div;
               tx_st  <= S_STOP;
            end else tx_cnt <= tx_cnt - 8'd1;
            S_STOP: if (tx_cnt == 8'd0) tx_st <= S_IDLE;
               else tx_cnt <= tx_cnt - 8'd1;
            default: begin
               tx_st <= S_IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

   // receive FSM plus RX data/flags; flag sets are ordered after read-clears so a set wins
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         rx_sync <= '1;
         rx_prev <= 1'b1;
         rx_st   <= S_IDLE;
         rx_cnt  <= 8'h00;
         rx_sh   <= 8'h00;
         rx_bit  <= 3'd0;
         rx_par  <= 1'b0;
         rx_data <= 8'h00;
         rx_full <= 1'b0;
         pe      <= 1'b0;
         fe      <= 1'b0;
         ovr     <= 1'b0;
      end else begin
         rx_sync <= {rx_sync[SYNC_STAGES-2:0], rx};
         rx_prev <= rx_s;
         if (pop)
            rx_full <= 1'b0;
         if (clr) begin
            pe  <= 1'b0;
            fe  <= 1'b0;
            ovr <= 1'b0;
         end
         case (rx_st)
            S_IDLE: if (rx_prev && !rx_s) begin
               rx_cnt <= rx_half;
               rx_st  <= S_START;
            end
            S_START: if (rx_cnt == 8'd0) begin
               if (rx_s)
                  rx_st <= S_IDLE;
               else begin
                  rx_cnt <= div;
                  rx_bit <= 3'd0;
                  rx_par <= 1'b0;
                  rx_st  <= S_DATA;
               end
            end else rx_cnt <= rx_cnt - 8'd1;
            S_DATA: if (rx_cnt == 8'd0) begin
               rx_sh  <= {rx_s, rx_sh[7:1]};
               rx_par <= rx_par ^ rx_s;
               rx_cnt <= div;
               rx_bit <= rx_bit + 3'd1;
               if (rx_bit == 3'd7)
                  rx_st <= PAR_EN ? S_PAR : S_STOP;
            end else rx_cnt <= rx_cnt - 8'd1;
            S_PAR: if (rx_cnt == 8'd0) begin
               if (rx_par != rx_s)
                  pe <= 1'b1;
               rx_cnt <= div;
               rx_st  <= S_STOP;
            end else rx_cnt <= rx_cnt - 8'd1;
            S_STOP: if (rx_cnt == 8'd0) begin
               rx_st <= S_IDLE;
               if (!rx_s)
                  fe <= 1'b1;
               else if (rx_full && !pop)
                  ovr <= 1'b1;
               else begin
                  rx_data <= rx_sh;
                  rx_full <= 1'b1;
               end
            end else rx_cnt <= rx_cnt - 8'd1;
            default: rx_st <= S_IDLE;
         endcase
      end
   end

endmodule
